alu_instr_sequencer: RTL and testbench



---
 rtl/alu_instr_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - Moore control sequencer for instruction fetch and ALU execute steps.
module alu_instr_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                LOin,
    output logic                HIin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [OPC_W-1:0]    alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t state_q, state_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_rr, is_wide, is_un;
    logic       ra_ok, rb_ok, rc_ok, legal;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    assign is_rr   = (opcode <= 5'd8);
    assign is_wide = (opcode == 5'd15) || (opcode == 5'd16);
    assign is_un   = (opcode == 5'd17) || (opcode == 5'd18);

    // A field only matters if the instruction class actually reads it.
    assign ra_ok = ({1'b0, ra} < 5'(NUM_REGS));
    assign rb_ok = ({1'b0, rb} < 5'(NUM_REGS));
    assign rc_ok = ({1'b0, rc} < 5'(NUM_REGS));
    assign legal = (is_rr & ra_ok & rb_ok & rc_ok)
                 | (is_wide & rb_ok & rc_ok)
                 | (is_un & ra_ok & rb_ok);

    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (idx == 4'(i));
        end
        return v;
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        alu_op   = '0;
        done     = 1'b0;
        illegal  = 1'b0;
        busy     = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_T0;
                end
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                // Re-driving PCin while stalled rewrites the same incremented PC.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) begin
                    state_d = S_T2;
                end
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (!legal) begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (!is_un) begin
                        Rout = onehot(rb);
                        Yin  = 1'b1;
                    end
                    state_d = S_T4;
                end
            end
            S_T4: begin
                alu_op  = OPC_W'(opcode);
                Rout    = is_un ? onehot(rb) : onehot(rc);
                Zlowin  = 1'b1;
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_wide) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = onehot(ra);
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - Self-checking bench for alu_instr_sequencer.
module tb_alu_instr_sequencer;

    localparam logic [13:0] PCOUT    = 14'h2000;
    localparam logic [13:0] MARIN    = 14'h1000;
    localparam logic [13:0] INCPC    = 14'h0800;
    localparam logic [13:0] PCIN     = 14'h0400;
    localparam logic [13:0] READ     = 14'h0200;
    localparam logic [13:0] MDRIN    = 14'h0100;
    localparam logic [13:0] MDROUT   = 14'h0080;
    localparam logic [13:0] IRIN     = 14'h0040;
    localparam logic [13:0] YIN      = 14'h0020;
    localparam logic [13:0] ZLOWIN   = 14'h0010;
    localparam logic [13:0] ZLOWOUT  = 14'h0008;
    localparam logic [13:0] ZHIGHOUT = 14'h0004;
    localparam logic [13:0] LOIN     = 14'h0002;
    localparam logic [13:0] HIIN     = 14'h0001;

    localparam logic [31:0] AND_IR = 32'h1091_8000;
    localparam logic [31:0] MUL_IR = 32'h7918_0000;
    localparam logic [31:0] ILL_IR = 32'h6000_0000;
    localparam logic [31:0] NEG_IR = 32'h8AB0_0000;

    logic        clock = 1'b0;
    logic        clear, start, mem_ready;
    logic [31:0] ir;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zlowin, Zlowout, Zhighout, LOin, HIin;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic        busy, done, illegal;

    always #5 clock = ~clock;

    alu_instr_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done),
        .illegal(illegal)
    );

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Model: each accepted instruction becomes a list of expected step outputs.
    typedef struct packed {
        logic [13:0] s;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
        logic        busy;
        logic        done;
        logic        ill;
        logic        t1;
    } step_t;

    step_t model_q[$];

    function automatic step_t mk(input logic [13:0] s, input logic [15:0] rin,
                                 input logic [15:0] rout, input logic [4:0] op,
                                 input logic dn, input logic il, input logic t1);
        step_t e;
        e.s = s; e.rin = rin; e.rout = rout; e.op = op;
        e.busy = 1'b1; e.done = dn; e.ill = il; e.t1 = t1;
        return e;
    endfunction

    task automatic push_seq(input logic [31:0] iv);
        logic [4:0] o;
        logic [3:0] a, b, c;
        bit rr, wd, un;
        o = iv[31:27]; a = iv[26:23]; b = iv[22:19]; c = iv[18:15];
        rr = (o <= 8); wd = (o == 15 || o == 16); un = (o == 17 || o == 18);
        model_q.push_back(mk(PCOUT | MARIN | INCPC | ZLOWIN, 0, 0, 0, 0, 0, 0));
        model_q.push_back(mk(ZLOWOUT | PCIN | READ | MDRIN, 0, 0, 0, 0, 0, 1));
        model_q.push_back(mk(MDROUT | IRIN, 0, 0, 0, 0, 0, 0));
        if (!(rr || wd || un)) begin
            model_q.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        end else begin
            if (un) model_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            else    model_q.push_back(mk(YIN, 0, 16'(1) << b, 0, 0, 0, 0));
            model_q.push_back(mk(ZLOWIN, 0, 16'(1) << (un ? b : c), o, 0, 0, 0));
            if (wd) begin
                model_q.push_back(mk(ZLOWOUT | LOIN, 0, 0, 0, 0, 0, 0));
                model_q.push_back(mk(ZHIGHOUT | HIIN, 0, 0, 0, 1, 0, 0));
            end else begin
                model_q.push_back(mk(ZLOWOUT, 16'(1) << a, 0, 0, 1, 0, 0));
            end
        end
    endtask

    always @(posedge clock) begin
        if (clear) begin
            model_q.delete();
        end else if (model_q.size() != 0) begin
            if (!(model_q[0].t1 && !mem_ready)) void'(model_q.pop_front());
        end else if (start) begin
            push_seq(ir);
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            step_t e;
            logic [53:0] ev, av;
            e  = (model_q.size() != 0) ? model_q[0] : '0;
            ev = e[54:1];
            av = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowin,
                  Zlowout, Zhighout, LOin, HIin, Rin, Rout, alu_op, busy, done, illegal};
            total++;
            if (av !== ev) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t act=%h exp=%h", $time, av, ev);
            end
        end
    end

    // Minimal datapath so the and instruction produces a real register result.
    logic [31:0] regs [16];
    logic [31:0] y_r, z_r, bus;

    always @* begin
        bus = 32'h0;
        for (int i = 0; i < 16; i++) if (Rout[i]) bus = regs[i];
        if (Zlowout) bus = z_r;
    end

    always @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
            regs[2] <= 32'h3;
            regs[3] <= 32'hD;
            y_r <= 32'h0;
            z_r <= 32'h0;
        end else begin
            if (Yin) y_r <= bus;
            if (Zlowin) begin
                case (alu_op)
                    5'd0:    z_r <= y_r + bus;
                    5'd1:    z_r <= y_r - bus;
                    5'd2:    z_r <= y_r & bus;
                    5'd3:    z_r <= y_r | bus;
                    default: z_r <= 32'h0;
                endcase
            end
            for (int i = 0; i < 16; i++) if (Rin[i]) regs[i] <= bus;
        end
    end

    logic [15:0] rin_at [64];
    logic [15:0] rout_at [64];
    logic [4:0]  op_at [64];
    logic        lo_at [64];
    logic        hi_at [64];
    int          rin_seen;

    task automatic issue(input logic [31:0] iv, input int stall, input int pulse_at,
                         input int exp_cyc, input bit exp_ill, input string nm);
        int c;
        @(negedge clock);
        ir = iv; start = 1'b1; mem_ready = 1'b1;
        @(negedge clock);
        start = 1'b0; c = 1; rin_seen = 0;
        while (c < 40) begin
            rin_at[c] = Rin; rout_at[c] = Rout; op_at[c] = alu_op;
            lo_at[c] = LOin; hi_at[c] = HIin;
            if (Rin != 0) rin_seen++;
            if (exp_ill ? illegal : done) break;
            mem_ready = !(c >= 2 && c < 2 + stall);
            start = (c == pulse_at);
            c++;
            @(negedge clock);
        end
        start = 1'b0; mem_ready = 1'b1;
        chk(nm, c, exp_cyc);
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; mem_ready = 1'b1; ir = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        armed = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_illegal", illegal, 0);
        chk("reset_rin", Rin, 0);
        chk("reset_rout", Rout, 0);

        issue(AND_IR, 0, -1, 6, 0, "and_latency");
        chk("and_t3_rout", rout_at[4], 16'h0004);
        chk("and_t4_rout", rout_at[5], 16'h0008);
        chk("and_t4_aluop", op_at[5], 2);
        chk("and_t5_rin", rin_at[6], 16'h0002);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_in_done_ignored", busy, 0);
        chk("and_r1_result", regs[1], 32'h1);

        issue(AND_IR, 3, -1, 9, 0, "stall_latency");
        chk("stall_t5_rin", rin_at[9], 16'h0002);

        issue(MUL_IR, 0, 4, 7, 0, "mul_latency");
        chk("mul_t5_loin", lo_at[6], 1);
        chk("mul_t6_hiin", hi_at[7], 1);
        chk("mul_no_rin", rin_seen, 0);

        issue(ILL_IR, 0, -1, 4, 1, "illegal_latency");
        chk("illegal_no_rin", rin_seen, 0);
        @(negedge clock);
        chk("illegal_busy_c5", busy, 0);

        issue(NEG_IR, 0, -1, 6, 0, "neg_latency");
        chk("neg_t4_rout", rout_at[5], 16'h0040);
        chk("neg_t5_rin", rin_at[6], 16'h0020);

        @(negedge clock);
        ir = AND_IR; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("abort_in_t4", alu_op, 2);
        clear = 1'b1;
        @(negedge clock);
        chk("abort_busy", busy, 0);
        chk("abort_rin", Rin, 0);
        @(negedge clock);
        clear = 1'b0;
        chk("abort_busy_hold", busy, 0);
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
